// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, round index, key-schedule FSM states and
// the GF(2^8) helpers behind the S-box and round constants.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_KEY_W = 128;

  typedef logic [3:0] round_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (i != 0) r = gf_mul(r, a);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input round_t rc);
    logic [7:0] v;
    case (rc)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd8:    v = 8'h1b;
      4'd9:    v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/key_schedule_ctrl_keygen.sv
// One AES-128 key-expansion round: derives round key rc+1 from round key rc.
module KeyGeneration
  import aes_pkg::*;
(
  input  round_t                 rc,
  input  logic [AES_KEY_W-1:0]   key,
  output logic [AES_KEY_W-1:0]   next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, temp;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]) ^ rcon(rc), sbox(rot[23:16]),
                 sbox(rot[15:8]), sbox(rot[7:0])};

  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key schedule: one shared KeyGeneration round stepped over
// ten cycles into an eleven-entry round-key bank with flat and registered reads.
//
// state  | meaning
// IDLE   | after reset, no keys expanded
// EXPAND | one round key written per cycle, start ignored
// READY  | all keys valid; start restarts expansion
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [AES_KEY_W-1:0]          key_in,
  input  logic [3:0]                    rd_round,
  output logic [AES_KEY_W-1:0]          rd_key,
  output logic                          busy,
  output logic                          done,
  output logic                          key_valid,
  output logic [(NR+1)*AES_KEY_W-1:0]   keys_all
);

  localparam round_t LAST_RC = round_t'(NR - 1);
  localparam round_t RD_MAX  = round_t'(NR);

  ks_state_t              state, next_state;
  round_t                 cnt;
  logic [AES_KEY_W-1:0]   rk [0:NR];
  logic [AES_KEY_W-1:0]   cur_key, next_key;
  logic                   load, step, last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE, READY: begin
        if (start) begin
          load       = 1'b1;
          next_state = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (cnt == LAST_RC) begin
          last       = 1'b1;
          next_state = READY;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy    = (state == EXPAND);
  assign cur_key = rk[cnt];

  KeyGeneration u_keygen (
    .rc       (cnt),
    .key      (cur_key),
    .next_key (next_key)
  );

  // cnt returns to 0 after the last round so it never leaves 0..NR-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      key_valid <= 1'b0;
      rd_key    <= '0;
    end else begin
      done   <= last;
      rd_key <= (rd_round <= RD_MAX) ? rk[rd_round] : '0;
      if (load) begin
        rk[0]     <= key_in;
        cnt       <= '0;
        key_valid <= 1'b0;
      end else if (step) begin
        rk[cnt + 4'd1] <= next_key;
        cnt            <= last ? '0 : cnt + 4'd1;
        if (last) key_valid <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_flat
    assign keys_all[(NR-g)*AES_KEY_W +: AES_KEY_W] = rk[g];
  end

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl using FIPS-197 key expansion vectors.
module tb_key_schedule_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [127:0]  key_in;
  logic [3:0]    rd_round;
  logic [127:0]  rd_key;
  logic          busy, done, key_valid;
  logic [1407:0] keys_all;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]   rd;
    logic [127:0] exp;
  } vec_t;

  vec_t         vecs [16];
  logic [127:0] fips_rk [0:10];
  logic [127:0] key_a, key_b, key_b_r10;

  key_schedule_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .rd_round  (rd_round),
    .rd_key    (rd_key),
    .busy      (busy),
    .done      (done),
    .key_valid (key_valid),
    .keys_all  (keys_all)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < bound);
  endtask

  initial begin
    int n;
    int dcnt;
    int dpos [3];
    logic bad;
    logic [1407:0] snap;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key_a       = fips_rk[0];
    key_b       = 128'h000102030405060708090a0b0c0d0e0f;
    key_b_r10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 0; i < 16; i++) begin
      vecs[i].rd  = 4'(i);
      vecs[i].exp = (i <= 10) ? fips_rk[i] : 128'h0;
    end

    rst = 1'b1; start = 1'b0; key_in = '0; rd_round = 4'd0;
    tick(); tick();
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    chk("rst_key_valid", {127'b0, key_valid}, 128'd0);
    chk("rst_rd_key", rd_key, 128'h0);
    chk("rst_keys_all_nz", {127'b0, |keys_all}, 128'd0);
    rst = 1'b0;
    tick();

    // FIPS-197 expansion, single start pulse
    start = 1'b1; key_in = key_a;
    tick();
    start = 1'b0; key_in = '0;
    chk("accept_busy", {127'b0, busy}, 128'd1);
    chk("accept_valid", {127'b0, key_valid}, 128'd0);
    wait_done(20, n);
    chk("fips_latency", 128'(n), 128'd10);
    chk("fips_valid", {127'b0, key_valid}, 128'd1);
    chk("fips_busy_off", {127'b0, busy}, 128'd0);
    chk("fips_flat_r10", keys_all[127:0], fips_rk[10]);
    chk("fips_flat_r0", keys_all[1407:1280], fips_rk[0]);
    tick();
    chk("done_one_cycle", {127'b0, done}, 128'd0);

    // Read-port sweep, including out-of-range indices
    for (int i = 0; i < 16; i++) begin
      rd_round = vecs[i].rd;
      tick();
      chk($sformatf("rd_round_%0d", i), rd_key, vecs[i].exp);
    end

    // Idle stability
    snap = keys_all;
    bad  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (!key_valid || done || busy || keys_all !== snap) bad = 1'b1;
    end
    chk("idle_stable", {127'b0, bad}, 128'd0);
    for (int i = 0; i <= 10; i++)
      chk($sformatf("flat_round_%0d", i), keys_all[(10-i)*128 +: 128], fips_rk[i]);

    // Restart from READY with a second key
    start = 1'b1; key_in = key_b;
    tick();
    start = 1'b0;
    chk("restart_valid_drop", {127'b0, key_valid}, 128'd0);
    chk("restart_busy", {127'b0, busy}, 128'd1);
    chk("restart_old_r10_kept", keys_all[127:0], fips_rk[10]);
    wait_done(20, n);
    chk("restart_latency", 128'(n), 128'd10);
    rd_round = 4'd10;
    tick();
    chk("restart_r10", rd_key, key_b_r10);

    // start held high: done every 11 cycles, start during EXPAND ignored
    start = 1'b1; key_in = key_a;
    dcnt = 0;
    for (int c = 1; c <= 35; c++) begin
      tick();
      if (done) begin
        if (dcnt < 3) dpos[dcnt] = c;
        dcnt++;
      end
    end
    start = 1'b0;
    chk("held_done_count", 128'(dcnt), 128'd3);
    if (dcnt >= 3) begin
      chk("held_done_0", 128'(dpos[0]), 128'd11);
      chk("held_done_1", 128'(dpos[1]), 128'd22);
      chk("held_done_2", 128'(dpos[2]), 128'd33);
    end
    wait_done(15, n);
    chk("held_tail_done", {127'b0, done}, 128'd1);
    rd_round = 4'd10;
    tick();
    chk("held_r10", rd_key, fips_rk[10]);

    // Reset in the middle of an expansion
    start = 1'b1; key_in = key_b;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_busy", {127'b0, busy}, 128'd0);
    chk("midrst_done", {127'b0, done}, 128'd0);
    chk("midrst_valid", {127'b0, key_valid}, 128'd0);
    chk("midrst_rd_key", rd_key, 128'h0);
    chk("midrst_keys_all_nz", {127'b0, |keys_all}, 128'd0);
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done || busy) bad = 1'b1;
    end
    chk("midrst_no_done", {127'b0, bad}, 128'd0);
    rst = 1'b0;
    tick();
    start = 1'b1; key_in = key_a;
    tick();
    start = 1'b0;
    wait_done(20, n);
    chk("postrst_latency", 128'(n), 128'd10);
    rd_round = 4'd1;
    tick();
    chk("postrst_r1", rd_key, fips_rk[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
